// File: rtl/accum_cpu_param.sv
// Parametrised two-phase accumulator CPU: one 8-bit instruction per FETCH/EXEC pair.
// Latency: instruction latched on the FETCH edge; its result is visible after the following EXEC edge.
// Backpressure: en_i low freezes every register in any state; HALT is left only through rst.
module accum_cpu_param #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int PCW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic [7:0]     in_i,
  output logic [PCW-1:0] pc_o,
  output logic [DW-1:0]  acc_o,
  output logic           carry_o,
  output logic           zero_o,
  output logic           exec_o,
  output logic           halted_o
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic           carry_q, carry_d;
  logic [7:0]     ir_q, ir_d;
  logic [DW-1:0]  bank_q [NREG];
  logic           bank_we;

  // Operand fetch from the bank, plus the PC-width views used by the jumps.
  logic [RW-1:0]  r_idx;
  logic [DW-1:0]  rval;
  logic [DW:0]    sum;
  logic [PCW-1:0] acc_pc;
  logic [PCW-1:0] rval_pc;

  assign r_idx   = ir_q[RW-1:0];
  assign rval    = bank_q[r_idx];
  assign sum     = {1'b0, acc_q} + {1'b0, rval};
  assign acc_pc  = PCW'(acc_q);
  assign rval_pc = PCW'(rval);

  // State register; reset always returns to FETCH, even out of HALT.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state: alternate FETCH/EXEC while enabled; the HALT opcode parks the core.
  always_comb begin
    state_d = state_q;
    if (en_i) begin
      case (state_q)
        S_FETCH: state_d = S_EXEC;
        S_EXEC:  state_d = (ir_q == 8'h03) ? S_HALT : S_FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs: status decoded from the state, architectural registers shown directly.
  always_comb begin
    exec_o   = (state_q == S_EXEC);
    halted_o = (state_q == S_HALT);
    pc_o     = pc_q;
    acc_o    = acc_q;
    carry_o  = carry_q;
    zero_o   = (acc_q == '0);
  end

  // Datapath next-state: fetch latches ir and bumps pc; exec applies the decoded operation.
  always_comb begin
    pc_d    = pc_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ir_d    = ir_q;
    bank_we = 1'b0;
    if (en_i && state_q == S_FETCH) begin
      ir_d = in_i;
      pc_d = pc_q + PCW'(1);
    end else if (en_i && state_q == S_EXEC) begin
      casez (ir_q)
        8'b1???????: acc_d = {{(DW-7){ir_q[6]}}, ir_q[6:0]};
        8'h01:       acc_d = ~acc_q;
        8'h02:       acc_d = -acc_q;
        8'h04: begin
          carry_d = acc_q[DW-1];
          acc_d   = {acc_q[DW-2:0], 1'b0};
        end
        8'h05: begin
          carry_d = acc_q[0];
          acc_d   = {1'b0, acc_q[DW-1:1]};
        end
        8'b00010???: bank_we = 1'b1;
        8'b00011???: acc_d = rval;
        8'b00100???: {carry_d, acc_d} = sum;
        8'b00101???: begin
          acc_d   = acc_q - rval;
          carry_d = (rval > acc_q);
        end
        8'b00110???: acc_d = acc_q & rval;
        8'b00111???: acc_d = acc_q | rval;
        8'b01000???: acc_d = acc_q ^ rval;
        // Relative branch back from the already-incremented pc.
        8'b01001???: begin
          if (rval > acc_q) pc_d = pc_q - acc_pc;
        end
        8'b01010???: begin
          if (carry_q) pc_d = rval_pc;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset clears the whole register bank as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ir_q    <= '0;
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ir_q    <= ir_d;
      if (bank_we) bank_q[r_idx] <= acc_q;
    end
  end

endmodule

// File: tb/tb_accum_cpu_param.sv
module tb_accum_cpu_param;

  logic       clk = 1'b0;
  logic [1:0] rst_s = 2'b11;
  logic [1:0] en_s  = 2'b00;
  logic [7:0] in_s [2];

  logic [7:0]  pc_a, acc_a;
  logic        carry_a, zero_a, exec_a, halt_a;
  logic [3:0]  pc_b;
  logic [15:0] acc_b;
  logic        carry_b, zero_b, exec_b, halt_b;

  int n_cmp = 0;
  int n_err = 0;

  accum_cpu_param dut_a (
    .clk(clk), .rst(rst_s[0]), .en_i(en_s[0]), .in_i(in_s[0]),
    .pc_o(pc_a), .acc_o(acc_a), .carry_o(carry_a), .zero_o(zero_a),
    .exec_o(exec_a), .halted_o(halt_a)
  );

  accum_cpu_param #(.DW(16), .NREG(4), .PCW(4)) dut_b (
    .clk(clk), .rst(rst_s[1]), .en_i(en_s[1]), .in_i(in_s[1]),
    .pc_o(pc_b), .acc_o(acc_b), .carry_o(carry_b), .zero_o(zero_b),
    .exec_o(exec_b), .halted_o(halt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural state per instance, updated one whole instruction at a time.
  longint m_acc [2];
  bit     m_carry [2];
  longint m_pc [2];
  longint m_bank [2][8];
  bit     m_halt [2];

  function automatic longint dmask(input int s); return (s == 0) ? 64'hFF : 64'hFFFF; endfunction
  function automatic longint pmask(input int s); return (s == 0) ? 64'hFF : 64'hF; endfunction
  function automatic int dwid(input int s); return (s == 0) ? 8 : 16; endfunction
  function automatic int nreg(input int s); return (s == 0) ? 8 : 4; endfunction

  function automatic logic [63:0] get_pc(input int s);    return (s == 0) ? 64'(pc_a)    : 64'(pc_b);    endfunction
  function automatic logic [63:0] get_acc(input int s);   return (s == 0) ? 64'(acc_a)   : 64'(acc_b);   endfunction
  function automatic logic [63:0] get_carry(input int s); return (s == 0) ? 64'(carry_a) : 64'(carry_b); endfunction
  function automatic logic [63:0] get_zero(input int s);  return (s == 0) ? 64'(zero_a)  : 64'(zero_b);  endfunction
  function automatic logic [63:0] get_exec(input int s);  return (s == 0) ? 64'(exec_a)  : 64'(exec_b);  endfunction
  function automatic logic [63:0] get_halt(input int s);  return (s == 0) ? 64'(halt_a)  : 64'(halt_b);  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int s);
    m_acc[s] = 0; m_carry[s] = 0; m_pc[s] = 0; m_halt[s] = 0;
    for (int i = 0; i < 8; i++) m_bank[s][i] = 0;
  endtask

  task automatic model_exec(input int s, input logic [7:0] ins);
    longint dm, pm, a, b, t;
    int r;
    dm = dmask(s); pm = pmask(s); a = m_acc[s];
    r = int'(ins[2:0]) % nreg(s);
    b = m_bank[s][r];
    m_pc[s] = (m_pc[s] + 1) & pm;
    if (ins[7]) begin
      t = longint'(ins[6:0]);
      if (ins[6]) t = t - 128;
      m_acc[s] = t & dm;
    end else begin
      case (ins[7:3])
        5'h00: case (ins[2:0])
          3'd1: m_acc[s] = ~a & dm;
          3'd2: m_acc[s] = (-a) & dm;
          3'd3: m_halt[s] = 1;
          3'd4: begin m_carry[s] = ((a >> (dwid(s) - 1)) & 1) != 0; m_acc[s] = (a << 1) & dm; end
          3'd5: begin m_carry[s] = (a & 1) != 0; m_acc[s] = a >> 1; end
          default: ;
        endcase
        5'h02: m_bank[s][r] = a;
        5'h03: m_acc[s] = b;
        5'h04: begin t = a + b; m_carry[s] = (t > dm); m_acc[s] = t & dm; end
        5'h05: begin m_carry[s] = (b > a); m_acc[s] = (a - b) & dm; end
        5'h06: m_acc[s] = a & b;
        5'h07: m_acc[s] = a | b;
        5'h08: m_acc[s] = a ^ b;
        5'h09: if (b > a) m_pc[s] = (m_pc[s] - a) & pm;
        5'h0A: if (m_carry[s]) m_pc[s] = b & pm;
        default: ;
      endcase
    end
  endtask

  task automatic check_state(input int s, input string tag);
    chk({tag, "_acc"},    get_acc(s),   m_acc[s]);
    chk({tag, "_carry"},  get_carry(s), 64'(m_carry[s]));
    chk({tag, "_pc"},     get_pc(s),    m_pc[s]);
    chk({tag, "_zero"},   get_zero(s),  64'(m_acc[s] == 0));
    chk({tag, "_exec"},   get_exec(s),  64'd0);
    chk({tag, "_halted"}, get_halt(s),  64'(m_halt[s]));
  endtask

  task automatic do_rst(input int s, input int n);
    rst_s[s] = 1'b1;
    en_s[s]  = 1'($urandom);
    repeat (n) begin
      in_s[s] = 8'($urandom);
      cyc();
    end
    rst_s[s] = 1'b0;
    en_s[s]  = 1'b0;
    model_reset(s);
    check_state(s, $sformatf("rst%0d", s));
  endtask

  // One instruction with optional stall cycles before FETCH and between FETCH and EXEC.
  task automatic run(input int s, input logic [7:0] ins, input int fs, input int es);
    longint pexp, aexp;
    pexp = (m_pc[s] + 1) & pmask(s);
    aexp = m_acc[s];
    en_s[s] = 1'b0;
    in_s[s] = ins;
    repeat (fs) cyc();
    en_s[s] = 1'b1;
    cyc();
    chk("mid_exec", get_exec(s), 64'd1);
    chk("mid_pc",   get_pc(s),   pexp);
    en_s[s] = 1'b0;
    in_s[s] = 8'($urandom);
    repeat (es) begin
      cyc();
      chk("stall_acc",  get_acc(s),  aexp);
      chk("stall_exec", get_exec(s), 64'd1);
    end
    en_s[s] = 1'b1;
    cyc();
    en_s[s] = 1'b0;
    model_exec(s, ins);
    check_state(s, $sformatf("i%0d_%02h", s, ins));
  endtask

  function automatic logic [7:0] rnd_ins();
    logic [7:0] v;
    v = 8'($urandom);
    case ($urandom_range(0, 3))
      1, 2: v = 8'h10 + 8'($urandom_range(0, 8'h47));
      3:    v = 8'($urandom_range(0, 7));
      default: ;
    endcase
    if (v == 8'h03) v = 8'h00;
    return v;
  endfunction

  typedef struct {
    bit         rst;
    logic [7:0] ins;
    logic [7:0] acc;
    bit         carry;
    logic [7:0] pc;
  } vec_t;

  vec_t tab[$];

  task automatic add(input bit r, input logic [7:0] ins, input logic [7:0] acc,
                     input bit c, input logic [7:0] pc);
    vec_t v;
    v.rst = r; v.ins = ins; v.acc = acc; v.carry = c; v.pc = pc;
    tab.push_back(v);
  endtask

  initial begin
    in_s[0] = 8'h00;
    in_s[1] = 8'h00;

    // Reset with random instruction input on both instances.
    do_rst(0, 2);
    do_rst(1, 2);

    // ALU / carry program
    add(0, 8'h85, 8'h05, 0, 8'd1);
    add(0, 8'h12, 8'h05, 0, 8'd2);
    add(0, 8'hFD, 8'hFD, 0, 8'd3);
    add(0, 8'h22, 8'h02, 1, 8'd4);
    add(0, 8'h2A, 8'hFD, 1, 8'd5);
    // Taken BGT from pc 6, then JC, then undefined opcodes
    add(1, 8'h00, 8'h00, 0, 8'd0);
    add(0, 8'h8A, 8'h0A, 0, 8'd1);
    add(0, 8'h11, 8'h0A, 0, 8'd2);
    add(0, 8'h83, 8'h03, 0, 8'd3);
    add(0, 8'h00, 8'h03, 0, 8'd4);
    add(0, 8'h00, 8'h03, 0, 8'd5);
    add(0, 8'h00, 8'h03, 0, 8'd6);
    add(0, 8'h49, 8'h03, 0, 8'd4);
    add(0, 8'hFF, 8'hFF, 0, 8'd5);
    add(0, 8'h04, 8'hFE, 1, 8'd6);
    add(0, 8'h51, 8'hFE, 1, 8'd10);
    add(0, 8'h06, 8'hFE, 1, 8'd11);
    add(0, 8'h58, 8'hFE, 1, 8'd12);
    add(0, 8'h7F, 8'hFE, 1, 8'd13);
    // Not-taken BGT from pc 6, then logic ops
    add(1, 8'h00, 8'h00, 0, 8'd0);
    add(0, 8'h82, 8'h02, 0, 8'd1);
    add(0, 8'h11, 8'h02, 0, 8'd2);
    add(0, 8'h83, 8'h03, 0, 8'd3);
    add(0, 8'h00, 8'h03, 0, 8'd4);
    add(0, 8'h00, 8'h03, 0, 8'd5);
    add(0, 8'h00, 8'h03, 0, 8'd6);
    add(0, 8'h49, 8'h03, 0, 8'd7);
    add(0, 8'h01, 8'hFC, 0, 8'd8);
    add(0, 8'h02, 8'h04, 0, 8'd9);
    add(0, 8'h05, 8'h02, 0, 8'd10);
    add(0, 8'h31, 8'h02, 0, 8'd11);
    add(0, 8'h41, 8'h00, 0, 8'd12);
    add(0, 8'h39, 8'h02, 0, 8'd13);
    add(0, 8'h1A, 8'h00, 0, 8'd14);

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rst) do_rst(0, 2);
      else            run(0, tab[i].ins, 0, 0);
      chk($sformatf("tab%0d_acc", i),   get_acc(0),   64'(tab[i].acc));
      chk($sformatf("tab%0d_carry", i), get_carry(0), 64'(tab[i].carry));
      chk($sformatf("tab%0d_pc", i),    get_pc(0),    64'(tab[i].pc));
    end

    // Stall in FETCH and between FETCH and EXEC of LDI 7.
    run(0, 8'h87, 2, 3);
    chk("stall_ldi7", get_acc(0), 64'h07);

    // HALT freezes everything for 20 cycles of arbitrary input.
    run(0, 8'h03, 0, 0);
    for (int i = 0; i < 20; i++) begin
      en_s[0] = 1'($urandom);
      in_s[0] = 8'($urandom);
      cyc();
      chk("halt_pc",  get_pc(0),   m_pc[0]);
      chk("halt_acc", get_acc(0),  m_acc[0]);
      chk("halt_hld", get_halt(0), 64'd1);
    end
    en_s[0] = 1'b0;
    do_rst(0, 1);

    // Reset in the middle of EXEC discards the pending instruction.
    run(0, 8'h85, 0, 0);
    en_s[0] = 1'b1;
    in_s[0] = 8'h7A;
    cyc();
    chk("rstx_exec", get_exec(0), 64'd1);
    rst_s[0] = 1'b1;
    cyc();
    rst_s[0] = 1'b0;
    en_s[0]  = 1'b0;
    model_reset(0);
    check_state(0, "rstx");

    // Wide-data / narrow-pc instance.
    run(1, 8'hC0, 0, 0);
    chk("b_ldi_sext", get_acc(1), 64'hFFC0);
    run(1, 8'h16, 0, 0);
    run(1, 8'h80, 0, 0);
    chk("b_zero", get_zero(1), 64'd1);
    run(1, 8'h1A, 0, 0);
    chk("b_sta_r6_r2", get_acc(1), 64'hFFC0);
    for (int i = 0; i < 16 && m_pc[1] != 15; i++) run(1, 8'h00, 0, 0);
    run(1, 8'h00, 0, 0);
    chk("b_pc_wrap", get_pc(1), 64'd0);
    run(1, 8'h81, 0, 0);
    for (int i = 0; i < 15; i++) run(1, 8'h04, 0, 0);
    chk("b_shl_8000", get_acc(1), 64'h8000);
    run(1, 8'h04, 0, 0);
    chk("b_shl_acc",   get_acc(1),   64'd0);
    chk("b_shl_carry", get_carry(1), 64'd1);
    chk("b_shl_zero",  get_zero(1),  64'd1);

    // Randomized programs with random stalls against the model.
    for (int s = 0; s < 2; s++) begin
      do_rst(s, 1);
      for (int i = 0; i < 250; i++) begin
        run(s, rnd_ins(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
